// File: rtl/tiled_matrix_multiplier.sv
// Tiled signed NxN multiplier (A*B or A*B^T). LANES rows of C per pass, result N*N/LANES edges after accept.
// Result held with o_ready low until i_ready. Elements are packed row-major, element (r,c) at index r*N+c (LSB first).
module tiled_matrix_multiplier #(
   parameter int MATRIX_SIZE   = 8,
   parameter int MAT1_BITWIDTH = 12,
   parameter int MAT2_BITWIDTH = 12,
   parameter int LANES         = 2,
   parameter int SHIFT         = 0,
   parameter int OUT_BITWIDTH  = MAT1_BITWIDTH + MAT2_BITWIDTH + $clog2(MATRIX_SIZE)
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             i_valid,
   output logic                                             o_ready,
   input  logic [MATRIX_SIZE*MATRIX_SIZE*MAT1_BITWIDTH-1:0] i_matrix1,
   input  logic [MATRIX_SIZE*MATRIX_SIZE*MAT2_BITWIDTH-1:0] i_matrix2,
   input  logic                                             i_transpose,
   output logic                                             o_valid,
   input  logic                                             i_ready,
   output logic [MATRIX_SIZE*MATRIX_SIZE*OUT_BITWIDTH-1:0]  o_matrix,
   output logic                                             o_overflow
);
   localparam int N      = MATRIX_SIZE;
   localparam int NP     = N / LANES;
   localparam int KW     = (N > 1) ? $clog2(N) : 1;
   localparam int PW     = (NP > 1) ? $clog2(NP) : 1;
   localparam int PROD_W = MAT1_BITWIDTH + MAT2_BITWIDTH;
   localparam int ACC_W  = PROD_W + $clog2(N);
   localparam int EXT_W  = ((ACC_W + 1 > OUT_BITWIDTH) ? ACC_W + 1 : OUT_BITWIDTH) + 1;
   localparam logic signed [EXT_W-1:0] OUT_MAX =
      {{(EXT_W-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
   localparam logic signed [EXT_W-1:0] RND =
      (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

   if (MATRIX_SIZE % LANES != 0) begin : g_lanes_check
      $error("MATRIX_SIZE must be a multiple of LANES");
   end

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

   state_t                          r_state, w_state_nxt;
   logic signed [MAT1_BITWIDTH-1:0] r_a   [N][N];
   logic signed [MAT2_BITWIDTH-1:0] r_b   [N][N];
   logic                            r_t;
   logic        [KW-1:0]            r_k;
   logic        [PW-1:0]            r_p;
   logic signed [ACC_W-1:0]         r_acc [LANES][N];
   logic        [OUT_BITWIDTH-1:0]  r_out [N][N];
   logic                            r_ovf;
   logic                            w_accept, w_last;
   logic        [KW-1:0]            w_row  [LANES];
   logic signed [PROD_W-1:0]        w_prod [LANES][N];
   logic signed [ACC_W-1:0]         w_sum  [LANES][N];
   logic signed [EXT_W-1:0]         w_rnd  [LANES][N];
   logic        [OUT_BITWIDTH-1:0]  w_res  [LANES][N];
   logic                            w_sat  [LANES][N];

   assign w_last = (r_state == S_COMPUTE) && (r_k == K_LAST) && (r_p == P_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) w_state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            o_valid = 1'b1;
            o_ready = i_ready;
            if (i_ready) w_state_nxt = i_valid ? S_COMPUTE : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_accept = o_ready & i_valid;
   end

   // MAC for all lanes/columns, then round, shift and saturate the running sum.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_row[l] = KW'(int'(r_p) * LANES + l);
         for (int j = 0; j < N; j++) begin
            w_prod[l][j] = PROD_W'(r_a[w_row[l]][r_k]) *
                           PROD_W'(r_t ? r_b[j][r_k] : r_b[r_k][j]);
            w_sum[l][j]  = r_acc[l][j] + ACC_W'(w_prod[l][j]);
            w_rnd[l][j]  = (EXT_W'(w_sum[l][j]) + RND) >>> SHIFT;
            w_sat[l][j]  = 1'b0;
            w_res[l][j]  = w_rnd[l][j][OUT_BITWIDTH-1:0];
            if (w_rnd[l][j] > OUT_MAX) begin
               w_res[l][j] = OUT_MAX[OUT_BITWIDTH-1:0];
               w_sat[l][j] = 1'b1;
            end else if (w_rnd[l][j] < OUT_MIN) begin
               w_res[l][j] = OUT_MIN[OUT_BITWIDTH-1:0];
               w_sat[l][j] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k   <= '0;
         r_p   <= '0;
         r_ovf <= 1'b0;
         for (int l = 0; l < LANES; l++)
            for (int j = 0; j < N; j++) r_acc[l][j] <= '0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) r_out[r][c] <= '0;
      end else if (w_accept) begin
         r_t   <= i_transpose;
         r_k   <= '0;
         r_p   <= '0;
         r_ovf <= 1'b0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_a[r][c] <= i_matrix1[(r*N+c)*MAT1_BITWIDTH +: MAT1_BITWIDTH];
               r_b[r][c] <= i_matrix2[(r*N+c)*MAT2_BITWIDTH +: MAT2_BITWIDTH];
            end
         end
      end else if (r_state == S_COMPUTE) begin
         if (r_k == K_LAST) begin
            r_k <= '0;
            r_p <= (r_p == P_LAST) ? '0 : r_p + PW'(1);
            for (int l = 0; l < LANES; l++) begin
               for (int j = 0; j < N; j++) begin
                  r_out[w_row[l]][j] <= w_res[l][j];
                  r_acc[l][j]        <= '0;
                  if (w_sat[l][j]) r_ovf <= 1'b1;
               end
            end
         end else begin
            r_k <= r_k + KW'(1);
            for (int l = 0; l < LANES; l++)
               for (int j = 0; j < N; j++) r_acc[l][j] <= w_sum[l][j];
         end
      end
   end

   for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
         assign o_matrix[(gr*N+gc)*OUT_BITWIDTH +: OUT_BITWIDTH] = r_out[gr][gc];
      end
   end

   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// Bench for tiled_matrix_multiplier: two instances (plain and shift/saturating) share stimulus,
// each checked against an element-wise arithmetic reference.
module tb_tiled_matrix_multiplier;
   localparam int N   = 4;
   localparam int W   = 8;
   localparam int OW0 = 18;
   localparam int OW1 = 8;
   localparam int LAT = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_valid, i_ready, i_transpose;
   logic [N*N*W-1:0]     i_matrix1, i_matrix2;
   logic                 o_ready0, o_valid0, o_overflow0;
   logic                 o_ready1, o_valid1, o_overflow1;
   logic [N*N*OW0-1:0]   o_matrix0;
   logic [N*N*OW1-1:0]   o_matrix1;

   int     m_a [N][N];
   int     m_b [N][N];
   longint exp0 [N][N];
   longint exp1 [N][N];
   bit     eovf0, eovf1;
   int     n_checks = 0;
   int     n_fail   = 0;

   always #5 clk = ~clk;

   tiled_matrix_multiplier #(.MATRIX_SIZE(N), .MAT1_BITWIDTH(W), .MAT2_BITWIDTH(W),
                             .LANES(2), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready0),
      .i_matrix1(i_matrix1), .i_matrix2(i_matrix2), .i_transpose(i_transpose),
      .o_valid(o_valid0), .i_ready(i_ready), .o_matrix(o_matrix0), .o_overflow(o_overflow0));

   tiled_matrix_multiplier #(.MATRIX_SIZE(N), .MAT1_BITWIDTH(W), .MAT2_BITWIDTH(W),
                             .LANES(2), .SHIFT(2), .OUT_BITWIDTH(OW1)) u_dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready1),
      .i_matrix1(i_matrix1), .i_matrix2(i_matrix2), .i_transpose(i_transpose),
      .o_valid(o_valid1), .i_ready(i_ready), .o_matrix(o_matrix1), .o_overflow(o_overflow1));

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint elem0(int i, int j);
      logic signed [OW0-1:0] v;
      v = o_matrix0[(i*N+j)*OW0 +: OW0];
      return longint'(v);
   endfunction

   function automatic longint elem1(int i, int j);
      logic signed [OW1-1:0] v;
      v = o_matrix1[(i*N+j)*OW1 +: OW1];
      return longint'(v);
   endfunction

   // C[i][j] = sum_k A[i][k]*B'[k][j], then floor((s + 2^(sh-1)) / 2^sh).
   function automatic longint ref_val(int i, int j, bit t, int sh);
      longint s = 0;
      longint d, q;
      for (int k = 0; k < N; k++)
         s += longint'(m_a[i][k]) * longint'(t ? m_b[j][k] : m_b[k][j]);
      if (sh == 0) return s;
      d = longint'(1) << sh;
      s = s + d / 2;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint clampv(longint v, int ow);
      longint lim;
      lim = longint'(1) << (ow - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim)    return -lim;
      return v;
   endfunction

   task automatic compute_expected(input bit t);
      longint r;
      eovf0 = 1'b0;
      eovf1 = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            r = ref_val(i, j, t, 0);
            exp0[i][j] = clampv(r, OW0);
            if (exp0[i][j] != r) eovf0 = 1'b1;
            r = ref_val(i, j, t, 2);
            exp1[i][j] = clampv(r, OW1);
            if (exp1[i][j] != r) eovf1 = 1'b1;
         end
      end
   endtask

   task automatic scramble();
      for (int w = 0; w < N*N*W/32; w++) begin
         i_matrix1[32*w +: 32] = $urandom;
         i_matrix2[32*w +: 32] = $urandom;
      end
      i_transpose = 1'($urandom_range(0, 1));
   endtask

   task automatic rand_mats();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            m_a[i][j] = int'($urandom_range(0, 255)) - 128;
            m_b[i][j] = int'($urandom_range(0, 255)) - 128;
         end
   endtask

   task automatic fill(input int av, input int bv, input bit ident_a, input bit seq_b);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            m_a[i][j] = ident_a ? ((i == j) ? 1 : 0) : av;
            m_b[i][j] = seq_b ? (i*N + j + 1) : bv;
         end
   endtask

   task automatic check_matrices();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            chk_eq($sformatf("d0_c%0d%0d", i, j), elem0(i, j), exp0[i][j]);
            chk_eq($sformatf("d1_c%0d%0d", i, j), elem1(i, j), exp1[i][j]);
         end
      chk_eq("d0_ovf", longint'(o_overflow0), longint'(eovf0));
      chk_eq("d1_ovf", longint'(o_overflow1), longint'(eovf1));
      chk_eq("d1_valid", longint'(o_valid1), 1);
   endtask

   task automatic check_zero();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            chk_eq("rst_d0_elem", elem0(i, j), 0);
            chk_eq("rst_d1_elem", elem1(i, j), 0);
         end
      chk_eq("rst_valid", longint'(o_valid0), 0);
      chk_eq("rst_ovf", longint'(o_overflow0 | o_overflow1), 0);
      chk_eq("rst_ready", longint'(o_ready0 & o_ready1), 1);
   endtask

   // Called at a negedge with the DUT ready; returns at the negedge after the accept.
   task automatic issue(input bit t);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            i_matrix1[(i*N+j)*W +: W] = W'(m_a[i][j]);
            i_matrix2[(i*N+j)*W +: W] = W'(m_b[i][j]);
         end
      i_transpose = t;
      i_valid     = 1'b1;
      #1;
      chk_eq("ready_at_issue", longint'(o_ready0), 1);
      compute_expected(t);
      @(negedge clk);
      chk_eq("ready_in_compute", longint'(o_ready0), 0);
      i_ready = 1'b0;
      i_valid = 1'($urandom_range(0, 1));
      scramble();
   endtask

   task automatic await_result();
      int lat = 0;
      while (!o_valid0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk_eq("latency", lat, LAT);
      check_matrices();
   endtask

   task automatic hold_release(input int hold, input bit chain, input bit t);
      for (int h = 0; h < hold; h++) begin
         chk_eq("hold_valid", longint'(o_valid0), 1);
         chk_eq("hold_ready", longint'(o_ready0), 0);
         i_valid = 1'b1;
         scramble();
         @(negedge clk);
      end
      check_matrices();
      i_ready = 1'b1;
      if (chain) begin
         issue(t);
      end else begin
         i_valid = 1'b0;
         @(negedge clk);
         chk_eq("drained_valid", longint'(o_valid0), 0);
         chk_eq("idle_ready", longint'(o_ready0), 1);
         i_ready = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk_eq("post_rst_valid", longint'(o_valid0), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit chain;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_transpose = 1'b0;
      i_matrix1 = '0; i_matrix2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_zero();
      @(negedge clk);

      fill(0, 0, 1'b1, 1'b1);
      issue(1'b0); await_result();
      chk_eq("ident_c12", elem0(1, 2), 7);
      hold_release(2, 1'b0, 1'b0);

      issue(1'b1); await_result();
      chk_eq("trans_c01", elem0(0, 1), 5);
      hold_release(0, 1'b0, 1'b0);

      fill(127, 127, 1'b0, 1'b0);
      issue(1'b0); await_result();
      chk_eq("sat_pos_c23", elem1(2, 3), 127);
      chk_eq("sat_pos_ovf", longint'(o_overflow1), 1);
      chk_eq("wide_c00", elem0(0, 0), 64516);
      hold_release(1, 1'b0, 1'b0);

      fill(-128, 127, 1'b0, 1'b0);
      issue(1'b1); await_result();
      chk_eq("sat_neg_c10", elem1(1, 0), -128);
      chk_eq("sat_neg_ovf", longint'(o_overflow1), 1);
      hold_release(0, 1'b0, 1'b0);

      fill(0, 0, 1'b1, 1'b0);
      m_a[0][0] = 6; m_a[1][1] = -6;
      for (int i = 0; i < N; i++) m_b[i][i] = 1;
      issue(1'b0); await_result();
      chk_eq("round_pos", elem1(0, 0), 2);
      chk_eq("round_neg", elem1(1, 1), -1);
      rand_mats();
      hold_release(10, 1'b1, 1'b1);
      await_result();
      hold_release(0, 1'b0, 1'b0);

      rand_mats();
      issue(1'b0); await_result();
      pulse_reset();

      rand_mats();
      issue(1'b1);
      repeat (2) @(negedge clk);
      pulse_reset();
      rand_mats();
      issue(1'b0); await_result();
      hold_release(1, 1'b0, 1'b0);

      rand_mats();
      issue(1'($urandom_range(0, 1)));
      for (int n = 0; n < 16; n++) begin
         await_result();
         chain = (n != 15) && ($urandom_range(0, 1) == 1);
         if (chain) begin
            rand_mats();
            hold_release(int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
         end else begin
            hold_release(int'($urandom_range(0, 3)), 1'b0, 1'b0);
            if (n != 15) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               rand_mats();
               issue(1'($urandom_range(0, 1)));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
